// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C EEPROM responder.
//   state_t             : responder FSM states
//   DEFAULT_DEVICE_ADDR : 7-bit bus address answered by default
//   ACK / NACK          : SDA levels of the acknowledge bit
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV_ADDR,
    ACK_DEV,
    ADDR_H,
    ACK_AH,
    ADDR_L,
    ACK_AL,
    WR_BYTE,
    ACK_WR,
    RD_BYTE,
    WAIT_MACK,
    IGNORE
  } state_t;

  localparam logic [6:0] DEFAULT_DEVICE_ADDR = 7'b1010_011;
  localparam logic       ACK                 = 1'b0;
  localparam logic       NACK                = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the sys_clk domain and derives one-cycle bus events.
// Ports:
//   sys_clk, sys_rst_n : system clock, asynchronous active-low reset
//   i_scl, i_sda       : raw bus pins
//   o_sda              : synchronized SDA level
//   o_scl_rise/fall    : one-cycle pulses on sampled SCL edges
//   o_start_det        : SDA fell while SCL high
//   o_stop_det         : SDA rose while SCL high
// Events appear combinationally after the 2-flop synchronizer, so the FSM
// acts on them 3 sys_clk after the pin edge.
module i2c_bus_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start_det,
  output logic o_stop_det
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_prev;
  logic       r_sda_prev;

  // Idle bus is high, so reset to 1 to avoid spurious events after reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i_scl};
      r_sda_sync <= {r_sda_sync[0], i_sda};
      r_scl_prev <= r_scl_sync[1];
      r_sda_prev <= r_sda_sync[1];
    end
  end

  assign o_sda       = r_sda_sync[1];
  assign o_scl_rise  =  r_scl_sync[1] & ~r_scl_prev;
  assign o_scl_fall  = ~r_scl_sync[1] &  r_scl_prev;
  assign o_start_det =  r_scl_sync[1] &  r_scl_prev & r_sda_prev & ~r_sda_sync[1];
  assign o_stop_det  =  r_scl_sync[1] &  r_scl_prev & ~r_sda_prev & r_sda_sync[1];

endmodule

// File: rtl/i2c_eeprom_slave.sv
// I2C responder emulating a 24Cxx-style serial EEPROM.
// Parameters:
//   DEVICE_ADDR : 7-bit bus address
//   ADDR_BYTES  : word-address length, 1 or 2 bytes
//   MEM_AW      : memory address width (depth 2^MEM_AW bytes, MEM_AW <= 16)
// Ports:
//   sys_clk, sys_rst_n : system clock (>= 16x SCL), async active-low reset
//   i2c_scl            : bus clock from the master
//   i2c_sda            : open-drain data line, driven 0 or released
//   wr_pulse           : one-cycle strobe when a byte is written to memory
//   wr_addr, wr_byte   : address and value of the written byte
//   busy               : high from a matched device address until STOP
// Build option:
//   I2C_SLAVE_SEQ_READ_EN : reads continue while the master ACKs; when
//                           undefined a read ends after one byte.
module i2c_eeprom_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEVICE_ADDR = DEFAULT_DEVICE_ADDR,
  parameter int unsigned ADDR_BYTES  = 2,
  parameter int unsigned MEM_AW      = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              i2c_scl,
  inout  wire               i2c_sda,
  output logic              wr_pulse,
  output logic [MEM_AW-1:0] wr_addr,
  output logic [7:0]        wr_byte,
  output logic              busy
);

  localparam int unsigned DEPTH     = 1 << MEM_AW;
  // Bit-count value marking "load next read byte on the coming SCL fall".
  localparam logic [3:0]  RD_RELOAD = 4'd9;

  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;
  logic w_seq_read;

  state_t            r_state;
  logic [3:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic [6:0]        r_tx;
  logic [7:0]        r_addr_hi;
  logic [MEM_AW-1:0] r_ptr;
  logic [7:0]        r_mem [DEPTH];
  logic              r_rw;
  logic              r_sda_oe;
  logic              r_busy;
  logic              r_wr_pulse;
  logic [MEM_AW-1:0] r_wr_addr;
  logic [7:0]        r_wr_byte;

  logic [7:0]        w_shift_next;
  logic [7:0]        w_rd_data;

  i2c_bus_sync u_bus_sync (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .i_scl       (i2c_scl),
    .i_sda       (i2c_sda),
    .o_sda       (w_sda),
    .o_scl_rise  (w_scl_rise),
    .o_scl_fall  (w_scl_fall),
    .o_start_det (w_start),
    .o_stop_det  (w_stop)
  );

`ifdef I2C_SLAVE_SEQ_READ_EN
  assign w_seq_read = 1'b1;
`else
  assign w_seq_read = 1'b0;
`endif

  assign w_shift_next = {r_shift[6:0], w_sda};
  assign w_rd_data    = r_mem[r_ptr];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx       <= '0;
      r_addr_hi  <= '0;
      r_ptr      <= '0;
      r_rw       <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_pulse <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_byte  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[MEM_AW'(i)] <= '0;
    end else begin
      r_wr_pulse <= 1'b0;
      if (w_start) begin
        r_state   <= DEV_ADDR;
        r_bit_cnt <= '0;
        r_sda_oe  <= 1'b0;
      end else if (w_stop) begin
        r_state   <= IDLE;
        r_bit_cnt <= '0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          DEV_ADDR, ADDR_H, ADDR_L, WR_BYTE: begin
            if (w_scl_rise && r_bit_cnt < 4'd8) begin
              r_shift   <= w_shift_next;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_state == WR_BYTE && r_bit_cnt == 4'd7) begin
                r_mem[r_ptr] <= w_shift_next;
                r_wr_pulse   <= 1'b1;
                r_wr_addr    <= r_ptr;
                r_wr_byte    <= w_shift_next;
                r_ptr        <= r_ptr + MEM_AW'(1);
              end
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_bit_cnt <= '0;
              case (r_state)
                DEV_ADDR: begin
                  if (r_shift[7:1] == DEVICE_ADDR) begin
                    r_state   <= ACK_DEV;
                    r_sda_oe  <= 1'b1;
                    r_busy    <= 1'b1;
                    r_rw      <= r_shift[0];
                    r_addr_hi <= '0;
                  end else begin
                    r_state <= IGNORE;
                  end
                end
                ADDR_H: begin
                  r_addr_hi <= r_shift;
                  r_state   <= ACK_AH;
                  r_sda_oe  <= 1'b1;
                end
                ADDR_L: begin
                  r_ptr    <= MEM_AW'({r_addr_hi, r_shift});
                  r_state  <= ACK_AL;
                  r_sda_oe <= 1'b1;
                end
                default: begin
                  r_state  <= ACK_WR;
                  r_sda_oe <= 1'b1;
                end
              endcase
            end
          end
          // The fall ending the device ACK also presents the first read bit.
          ACK_DEV: begin
            if (w_scl_fall) begin
              if (r_rw) begin
                r_state  <= RD_BYTE;
                r_tx     <= w_rd_data[6:0];
                r_sda_oe <= ~w_rd_data[7];
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= (ADDR_BYTES == 2) ? ADDR_H : ADDR_L;
              end
            end
          end
          ACK_AH: begin
            if (w_scl_fall) begin
              r_sda_oe <= 1'b0;
              r_state  <= ADDR_L;
            end
          end
          ACK_AL, ACK_WR: begin
            if (w_scl_fall) begin
              r_sda_oe <= 1'b0;
              r_state  <= WR_BYTE;
            end
          end
          RD_BYTE: begin
            if (w_scl_rise && r_bit_cnt < 4'd8) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_oe  <= 1'b0;
                r_ptr     <= r_ptr + MEM_AW'(1);
                r_bit_cnt <= '0;
                r_state   <= WAIT_MACK;
              end else if (r_bit_cnt == RD_RELOAD) begin
                r_tx      <= w_rd_data[6:0];
                r_sda_oe  <= ~w_rd_data[7];
                r_bit_cnt <= '0;
              end else begin
                r_sda_oe <= ~r_tx[6];
                r_tx     <= {r_tx[5:0], 1'b0};
              end
            end
          end
          // Master ACK re-enters RD_BYTE; the next byte loads on the next fall.
          WAIT_MACK: begin
            if (w_scl_rise) begin
              if (w_seq_read && w_sda == ACK) begin
                r_state   <= RD_BYTE;
                r_bit_cnt <= RD_RELOAD;
              end else begin
                r_state <= IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign i2c_sda  = r_sda_oe ? 1'b0 : 1'bz;
  assign wr_pulse = r_wr_pulse;
  assign wr_addr  = r_wr_addr;
  assign wr_byte  = r_wr_byte;
  assign busy     = r_busy;

endmodule

// File: doc/i2c_eeprom_slave.md
# i2c_eeprom_slave

I2C responder that emulates a 24Cxx-style serial EEPROM, which makes it the target side of the team's I2C EEPROM master. It samples SCL/SDA with `sys_clk`, decodes START/STOP, and matches the 7-bit device address. It takes a 1- or 2-byte word address, stores write data in an internal register array, and returns read data with auto-increment. It sits in simulation benches and in loopback FPGA builds as a stand-in for the physical EEPROM.

## Interface
- `DEVICE_ADDR`, 7'b1010_011, 7-bit address the block answers to.
- `ADDR_BYTES`, 2, word-address length in bytes; legal values are 1 or 2.
- `MEM_AW`, 8, memory address width; depth is 2^MEM_AW bytes.
- `sys_clk`  in  1  system clock. Must run ≥16× the SCL frequency (50 MHz vs 250 kHz nominal).
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `i2c_scl`  in  1  bus clock from the master.
- `i2c_sda`  inout  1  open-drain data line. The block drives 1'b0 or 1'bz, never 1'b1.
- `wr_pulse`  out  1  one-cycle strobe when a byte is committed to memory.
- `wr_addr`  out  MEM_AW  address of the committed byte.
- `wr_byte`  out  8  value of the committed byte.
- `busy`  out  1  high from a matched device address until STOP.

## Operation
- A 2-flop synchronizer on SCL and SDA feeds a registered previous-value stage.
  - Sampled SCL rise and fall come from comparing the synced and previous values.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- States: IDLE, DEV_ADDR, ACK_DEV, ADDR_H, ACK_AH, ADDR_L, ACK_AL, WR_BYTE, ACK_WR, RD_BYTE, WAIT_MACK, IGNORE.
- START from any state goes to DEV_ADDR, and the bit counter clears. This covers repeated START.
- STOP from any state goes to IDLE, releases SDA and clears `busy`.
- Bit shifting:
  - Bits are shifted MSB first on each SCL rise.
  - After the 8th bit, the block moves to its ACK state on the next SCL fall and drives SDA low for one SCL period.
- DEV_ADDR:
  - If bits [7:1] equal DEVICE_ADDR, the block sends ACK.
  - Otherwise it goes to IGNORE and SDA stays released.
  - R/W=0 leads to ADDR_H (ADDR_BYTES=2) or ADDR_L (ADDR_BYTES=1).
  - R/W=1 leads to RD_BYTE, using the current pointer.
- Address bytes:
  - ADDR_H and ADDR_L load the pointer; address bits above MEM_AW are discarded.
  - After ACK_AL the block goes to WR_BYTE.
- WR_BYTE:
  - The 8th sampled bit writes `mem[ptr]`, pulses `wr_pulse`, and increments `ptr`.
  - `ptr` increments modulo 2^MEM_AW, so it wraps at the top of memory.
  - The block then sends ACK_WR and returns to WR_BYTE, so any number of bytes can follow.
- RD_BYTE:
  - `mem[ptr]` is loaded into the TX shift register on entry to the state.
  - Each bit is driven on SCL fall; a 1 bit releases SDA.
  - `ptr` increments after the 8th bit.
  - WAIT_MACK samples SDA on SCL rise: ACK (0) leads to RD_BYTE, NACK (1) leads to IGNORE.
- IGNORE keeps SDA released and waits for START or STOP.
- A write followed by a repeated START with R/W=1 reads from the loaded pointer. This is the random-read sequence.

## Timing
- Bus events act on internal logic 3 `sys_clk` after the pin edge (2 synchronizer flops plus 1 edge register).
- SDA drive changes 1 `sys_clk` after the internal SCL-fall event. SDA is never changed while SCL is sampled high.
- `wr_pulse` asserts 1 cycle after the internal SCL rise of the 8th data bit.
- Reset values:
  - state=IDLE, ptr=0, memory=0, SDA released.
  - `wr_pulse`=0, `wr_addr`=0, `wr_byte`=0, `busy`=0.
- Reset mid-transfer releases SDA immediately; it is an asynchronous path.
- START or STOP arriving mid-byte aborts the byte with no memory write.

## Configuration
- `I2C_SLAVE_SEQ_READ_EN` defined: sequential reads continue while the master ACKs (WAIT_MACK ACK leads to RD_BYTE).
- Undefined: after one read byte the block goes to IGNORE regardless of ACK; `ptr` still increments.

## Structure
- Shared package `i2c_pkg`:
  - state enum;
  - default DEVICE_ADDR;
  - constants ACK=1'b0 and NACK=1'b1.
- One sub-module, `i2c_bus_sync`: synchronizers, edge detect, and `start_det`/`stop_det`/`scl_rise`/`scl_fall` pulses.
- Top level holds the FSM, shift registers, pointer and memory array.

## Test plan
- Byte write: master writes 0x5A to address 0x0010 → ACK on every byte, `wr_pulse` once with `wr_addr`=0x10 and `wr_byte`=0x5A, mem[0x10]=0x5A.
- Random read: dummy write of address 0x0010, repeated START, read with NACK → master receives 0x5A and the state reaches IGNORE.
- Wrong device address 0x50: no ACK (SDA stays high on the 9th clock), `busy`=0, memory unchanged.
- Page write at 0x00FE of 0x11, 0x22, 0x33 → mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33 (wrap).
- Sequential read of 3 bytes from 0xFE with macro defined → 0x11, 0x22, 0x33. With the macro undefined → 0x11, then 0xFF, 0xFF (SDA released).
- STOP after 4 data bits, or `sys_rst_n` low mid-byte → no `wr_pulse`, SDA released within 1 cycle of reset, and state is IDLE.
